branch_resolve_unit: RTL and testbench

Carries each fetched instruction's branch prediction (PrPCSrc_F, PrALUResult_F from the BHT-BTB) through Decode to Execute. There it compares the prediction with the resolved outcome and raises the predictor write-enables. On a misprediction it produces the corrected fetch PC and the flush requests. It sits downstream of the branch predictor and feeds its update port (PC_E, WE_PrPCSrc, WE_PrALUResult, ALUResult_E, PCSrc_E). It also feeds the PC-select mux and hazard unit.

---
 rtl/bp_pkg.sv | 12 +
 rtl/pred_pipe_reg.sv | 18 +
 rtl/branch_resolve_unit.sv | 80 ++++++++
 tb/tb_branch_resolve_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch prediction pipeline: the per-stage prediction
// bundle, its cleared value and the default fall-through increment.
package bp_pkg;
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  localparam int    PC_INC_DEF = 4;
  localparam pred_t PRED_CLEAR = '{valid: 1'b0, taken: 1'b0, target: 32'h0};
endpackage

// File: rtl/pred_pipe_reg.sv
// One prediction pipeline register.
// Priority: RESET, then clear (mispredict or flush), then stall, then load.
import bp_pkg::*;

module pred_pipe_reg (
  input  logic  clk,
  input  logic  RESET,
  input  logic  clear,
  input  logic  stall,
  input  pred_t d,
  output pred_t q
);
  always_ff @(posedge clk) begin
    if (RESET)       q <= PRED_CLEAR;
    else if (clear)  q <= PRED_CLEAR;
    else if (!stall) q <= d;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Carries F-stage branch predictions to Execute, resolves them against the
// real outcome, drives predictor updates and the fetch redirect.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
import bp_pkg::*;

module branch_resolve_unit #(
  parameter int PC_INC = PC_INC_DEF,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              PrPCSrc_F,
  input  logic [31:0]       PrALUResult_F,
  input  logic              StallD,
  input  logic              StallE,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       PC_E,
  input  logic              Branch_E,
  input  logic              PCSrc_E,
  input  logic [31:0]       ALUResult_E,
  output logic              WE_PrPCSrc,
  output logic              WE_PrALUResult,
  output logic              Mispredict_E,
  output logic [31:0]       RedirectPC_E,
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] MispredCount
);
  pred_t pred_f, pred_d, pred_e;
  logic  dir_miss, tgt_miss, ghost;

  assign pred_f = '{valid: 1'b1, taken: PrPCSrc_F, target: PrALUResult_F};

  // A redirect kills both younger slots even when the hazard unit stalls them.
  pred_pipe_reg u_pred_d (
    .clk(clk), .RESET(RESET), .clear(Mispredict_E | FlushD),
    .stall(StallD), .d(pred_f), .q(pred_d)
  );

  pred_pipe_reg u_pred_e (
    .clk(clk), .RESET(RESET), .clear(Mispredict_E | FlushE),
    .stall(StallE), .d(pred_d), .q(pred_e)
  );

  always_comb begin
    dir_miss = pred_e.valid & Branch_E & (PCSrc_E != pred_e.taken);
    tgt_miss = pred_e.valid & Branch_E & PCSrc_E & pred_e.taken &
               (ALUResult_E != pred_e.target);
    ghost    = pred_e.valid & ~Branch_E & pred_e.taken;

    Mispredict_E   = dir_miss | tgt_miss | ghost;
    WE_PrPCSrc     = pred_e.valid & (Branch_E | ghost);
    WE_PrALUResult = pred_e.valid & Branch_E & PCSrc_E & (~pred_e.taken | tgt_miss);

    RedirectPC_E = '0;
    if (pred_e.valid)
      RedirectPC_E = (Branch_E & PCSrc_E) ? ALUResult_E : PC_E + 32'(PC_INC);
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] br_cnt, mp_cnt;

  // Saturating counters so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (RESET) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (WE_PrPCSrc && Branch_E && br_cnt != '1) br_cnt <= br_cnt + STAT_W'(1);
      if (Mispredict_E && mp_cnt != '1)           mp_cnt <= mp_cnt + STAT_W'(1);
    end
  end

  assign BranchCount  = br_cnt;
  assign MispredCount = mp_cnt;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: expected Execute-stage results
// are queued when stimulus is driven and compared when the outputs settle.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        RESET;
  logic        PrPCSrc_F;
  logic [31:0] PrALUResult_F;
  logic        StallD, StallE, FlushD, FlushE;
  logic [31:0] PC_E;
  logic        Branch_E, PCSrc_E;
  logic [31:0] ALUResult_E;
  logic        WE_PrPCSrc, WE_PrALUResult, Mispredict_E;
  logic [31:0] RedirectPC_E;
  logic [31:0] BranchCount, MispredCount;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        mis;
    logic [31:0] rpc;
    logic        wepc;
    logic        wealu;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        te;
    logic [31:0] ae;
    logic [31:0] pc;
    logic        br;
    logic        src;
    logic [31:0] alu;
    exp_t        ex;
  } case_t;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_INC(4), .STAT_W(32)) dut (
    .clk(clk), .RESET(RESET),
    .PrPCSrc_F(PrPCSrc_F), .PrALUResult_F(PrALUResult_F),
    .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .PC_E(PC_E), .Branch_E(Branch_E), .PCSrc_E(PCSrc_E), .ALUResult_E(ALUResult_E),
    .WE_PrPCSrc(WE_PrPCSrc), .WE_PrALUResult(WE_PrALUResult),
    .Mispredict_E(Mispredict_E), .RedirectPC_E(RedirectPC_E),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_res();
    Branch_E = 1'b0; PCSrc_E = 1'b0; ALUResult_E = '0; PC_E = '0;
  endtask

  // Two unstalled cycles move an F-stage prediction into Execute.
  task automatic load_pred(input logic t, input logic [31:0] a);
    idle_res();
    PrPCSrc_F = t; PrALUResult_F = a;
    step();
    PrPCSrc_F = 1'b0; PrALUResult_F = '0;
    step();
  endtask

  // Independent reference for one Execute-cycle evaluation.
  function automatic exp_t model(input logic v, input logic te, input logic [31:0] ae,
                                 input logic [31:0] pc, input logic br, input logic src,
                                 input logic [31:0] alu);
    exp_t e;
    logic dm, tm, gh;
    dm = v && br && (src != te);
    tm = v && br && src && te && (alu != ae);
    gh = v && !br && te;
    e.mis   = dm || tm || gh;
    e.wepc  = v && (br || gh);
    e.wealu = v && br && src && (!te || tm);
    if (!v)            e.rpc = 32'h0;
    else if (br && src) e.rpc = alu;
    else               e.rpc = pc + 32'd4;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    RESET = 1'b1; StallD = 0; StallE = 0; FlushD = 0; FlushE = 0;
    PrPCSrc_F = 1'b1; PrALUResult_F = 32'h1234;
    PC_E = 32'h40; Branch_E = 1'b1; PCSrc_E = 1'b1; ALUResult_E = 32'h80;
    step(); step();
    sb.push_back('{mis: 1'b0, rpc: 32'h0, wepc: 1'b0, wealu: 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ({Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult} !==
        {e.mis, e.rpc, e.wepc, e.wealu}) begin
      n_fail++;
      $display("FAIL reset_outputs: got mis=%b rpc=%h we=%b%b want all zero",
               Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult);
    end
    n_tests++;
    if (BranchCount !== 32'h0 || MispredCount !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", BranchCount, MispredCount);
    end
    RESET = 1'b0; PrPCSrc_F = 1'b0; PrALUResult_F = '0;
    idle_res();
    step();
  endtask

  task automatic test_resolve();
    case_t c[8];
    exp_t  e;
    c[0] = '{1'b0, 32'h0,   32'h100,      1'b1, 1'b0, 32'h0,   '{1'b0, 32'h104, 1'b1, 1'b0}};
    c[1] = '{1'b0, 32'h0,   32'h100,      1'b1, 1'b1, 32'h200, '{1'b1, 32'h200, 1'b1, 1'b1}};
    c[2] = '{1'b1, 32'h300, 32'h100,      1'b1, 1'b1, 32'h340, '{1'b1, 32'h340, 1'b1, 1'b1}};
    c[3] = '{1'b1, 32'h300, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0,   '{1'b1, 32'h0,   1'b1, 1'b0}};
    c[4] = '{1'b1, 32'h300, 32'h100,      1'b1, 1'b1, 32'h300, '{1'b0, 32'h300, 1'b1, 1'b0}};
    c[5] = '{1'b0, 32'h0,   32'h800,      1'b0, 1'b0, 32'h0,   '{1'b0, 32'h804, 1'b0, 1'b0}};
    c[6] = '{1'b1, 32'h500, 32'h900,      1'b0, 1'b0, 32'h0,   '{1'b1, 32'h904, 1'b1, 1'b0}};
    c[7] = '{1'b0, 32'h0,   32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,   '{1'b0, 32'h0,   1'b0, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      load_pred(c[i].te, c[i].ae);
      PC_E = c[i].pc; Branch_E = c[i].br; PCSrc_E = c[i].src; ALUResult_E = c[i].alu;
      sb.push_back(c[i].ex);
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if ({Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult} !==
          {e.mis, e.rpc, e.wepc, e.wealu}) begin
        n_fail++;
        $display("FAIL resolve_case%0d: got mis=%b rpc=%h wepc=%b wealu=%b want mis=%b rpc=%h wepc=%b wealu=%b",
                 i, Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult,
                 e.mis, e.rpc, e.wepc, e.wealu);
      end
      step();
    end
  endtask

  // After a redirect the stale D and E slots must both come through invalid.
  task automatic test_flush_after_mispredict();
    load_pred(1'b0, 32'h0);
    PC_E = 32'h100; Branch_E = 1'b1; PCSrc_E = 1'b1; ALUResult_E = 32'h200;
    @(negedge clk);
    n_tests++;
    if (Mispredict_E !== 1'b1) begin
      n_fail++;
      $display("FAIL cold_taken_mis: got %b want 1", Mispredict_E);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      n_tests++;
      if ({Mispredict_E, WE_PrPCSrc, WE_PrALUResult, RedirectPC_E} !== 35'h0) begin
        n_fail++;
        $display("FAIL post_redirect_slot%0d: got mis=%b we=%b%b rpc=%h want all zero",
                 k, Mispredict_E, WE_PrPCSrc, WE_PrALUResult, RedirectPC_E);
      end
    end
    step();
  endtask

  task automatic test_stall();
    // Correct taken prediction held by a stall keeps resolving the same bundle.
    load_pred(1'b1, 32'h700);
    StallD = 1'b1; StallE = 1'b1;
    PC_E = 32'h600; Branch_E = 1'b1; PCSrc_E = 1'b1; ALUResult_E = 32'h700;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if ({Mispredict_E, WE_PrPCSrc, WE_PrALUResult, RedirectPC_E} !== {3'b010, 32'h700}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got mis=%b we=%b%b rpc=%h want mis=0 we=10 rpc=00000700",
                 k, Mispredict_E, WE_PrPCSrc, WE_PrALUResult, RedirectPC_E);
      end
      step();
    end
    // Flush beats stall.
    FlushE = 1'b1; FlushD = 1'b1;
    step();
    FlushE = 1'b0; FlushD = 1'b0;
    @(negedge clk);
    n_tests++;
    if (WE_PrPCSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got wepc=%b want 0", WE_PrPCSrc);
    end
    StallD = 1'b0; StallE = 1'b0;
    step();
    // Ghost hit while stalled: redirect still clears the held slots.
    load_pred(1'b1, 32'hABC0);
    StallD = 1'b1; StallE = 1'b1;
    PC_E = 32'h1000; Branch_E = 1'b0; PCSrc_E = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult} !== {1'b1, 32'h1004, 2'b10}) begin
      n_fail++;
      $display("FAIL ghost_stall: got mis=%b rpc=%h we=%b%b want mis=1 rpc=00001004 we=10",
               Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (Mispredict_E !== 1'b0 || WE_PrPCSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL ghost_stall_clear: got mis=%b wepc=%b want 0 0", Mispredict_E, WE_PrPCSrc);
    end
    StallD = 1'b0; StallE = 1'b0;
    step();
  endtask

  task automatic test_random();
    exp_t e;
    logic t, br, src;
    logic [31:0] a, pc, alu;
    for (int i = 0; i < 20; i++) begin
      t   = 1'($urandom_range(0, 1));
      a   = {$urandom_range(0, 3), 2'b00} << 4;
      br  = 1'($urandom_range(0, 1));
      src = br ? 1'($urandom_range(0, 1)) : 1'b0;
      alu = {$urandom_range(0, 3), 2'b00} << 4;
      pc  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      load_pred(t, a);
      PC_E = pc; Branch_E = br; PCSrc_E = src; ALUResult_E = alu;
      sb.push_back(model(1'b1, t, a, pc, br, src, alu));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if ({Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult} !==
          {e.mis, e.rpc, e.wepc, e.wealu}) begin
        n_fail++;
        $display("FAIL random%0d: got mis=%b rpc=%h we=%b%b want mis=%b rpc=%h we=%b%b",
                 i, Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult,
                 e.mis, e.rpc, e.wepc, e.wealu);
      end
      step();
    end
  endtask

  task automatic resolve_once(input logic t, input logic [31:0] a,
                              input logic src, input logic [31:0] alu);
    load_pred(t, a);
    PC_E = 32'h2000; Branch_E = 1'b1; PCSrc_E = src; ALUResult_E = alu;
    step();
    idle_res();
  endtask

  task automatic test_stats();
    logic [31:0] exp_br, exp_mp;
    RESET = 1'b1; step(); RESET = 1'b0;
    resolve_once(1'b0, 32'h0,   1'b0, 32'h0);
    resolve_once(1'b1, 32'h500, 1'b1, 32'h500);
    resolve_once(1'b0, 32'h0,   1'b1, 32'h600);
    step();
`ifdef BRANCH_STATS_EN
    exp_br = 32'd3; exp_mp = 32'd1;
`else
    exp_br = 32'd0; exp_mp = 32'd0;
`endif
    @(negedge clk);
    n_tests++;
    if (BranchCount !== exp_br || MispredCount !== exp_mp) begin
      n_fail++;
      $display("FAIL stats_counts: got %0d/%0d want %0d/%0d",
               BranchCount, MispredCount, exp_br, exp_mp);
    end
    RESET = 1'b1; step(); RESET = 1'b0;
    @(negedge clk);
    n_tests++;
    if (BranchCount !== 32'h0 || MispredCount !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", BranchCount, MispredCount);
    end
  endtask

  task automatic test_midop_reset();
    load_pred(1'b1, 32'h440);
    PC_E = 32'h400; Branch_E = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult} !== 35'h0) begin
      n_fail++;
      $display("FAIL midop_reset: got mis=%b rpc=%h we=%b%b want all zero",
               Mispredict_E, RedirectPC_E, WE_PrPCSrc, WE_PrALUResult);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_resolve();
    test_flush_after_mispredict();
    test_stall();
    test_random();
    test_midop_reset();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
